// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//
// Accepts a stream of unsigned 8-bit pixels, converts each one to int8 by
// subtracting ZERO_POINT (saturating), and writes it into the inference
// core's input buffer. A frame is complete when exactly IN_DIM pixels arrive
// with s_last on the final one. The core is then started, the predicted digit
// is captured, and it is offered on a valid/ready result port.
//
// Malformed frames never start the core:
//   - s_last too early : err_short pulses and the loader restarts at address 0.
//   - s_last missing   : err_long pulses and the remaining pixels are drained
//                        until s_last, without writing.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_valid/s_ready   pixel stream handshake; s_data pixel, s_last end of frame
//   x_we/x_addr/x_data  input-buffer write port (registered)
//   core_start        one-cycle pulse starting the inference core
//   core_done         one-cycle completion pulse; core_digit valid with it
//   m_valid/m_ready   result handshake; m_digit result digit
//   busy              high whenever the loader is not in S_LOAD
//   err_short/err_long  one-cycle framing error pulses
//   frame_cnt         number of results delivered (wraps at 16 bits)
// -----------------------------------------------------------------------------
module image_loader #(
  parameter int IN_DIM     = 784,
  parameter int ZERO_POINT = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  // pixel stream
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [7:0]                s_data,
  input  logic                      s_last,
  // input buffer write port
  output logic                      x_we,
  output logic [$clog2(IN_DIM)-1:0] x_addr,
  output logic [7:0]                x_data,
  // inference core
  output logic                      core_start,
  input  logic                      core_done,
  input  logic [3:0]                core_digit,
  // result stream
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [3:0]                m_digit,
  // status
  output logic                      busy,
  output logic                      err_short,
  output logic                      err_long,
  output logic [15:0]               frame_cnt
);

  localparam int AW = $clog2(IN_DIM);
  localparam logic [AW-1:0] CNT_LAST = AW'(IN_DIM - 1);

  // Saturation bounds and zero point in the 10-bit signed domain used for
  // the pixel difference.
  localparam logic signed [9:0] ZP10    = 10'(ZERO_POINT);
  localparam logic signed [9:0] SAT_MAX = 10'sd127;
  localparam logic signed [9:0] SAT_MIN = -10'sd128;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          x_we_q, x_we_d;
  logic [AW-1:0] x_addr_q, x_addr_d;
  logic [7:0]    x_data_q, x_data_d;
  logic          core_start_q, core_start_d;
  logic          m_valid_q, m_valid_d;
  logic [3:0]    m_digit_q, m_digit_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          hs;
  logic          at_last_pix;

  // Convert an unsigned pixel to int8: widen to 10-bit signed, subtract the
  // zero point, clamp to the int8 range.
  function automatic logic [7:0] sat8(input logic [7:0] pix);
    logic signed [9:0] diff;
    diff = $signed({2'b00, pix}) - ZP10;
    if (diff > SAT_MAX) begin
      return 8'h7f;
    end else if (diff < SAT_MIN) begin
      return 8'h80;
    end else begin
      return diff[7:0];
    end
  endfunction

  assign hs          = s_valid & s_ready_q;
  assign at_last_pix = (cnt_q == CNT_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_we_d       = 1'b0;
    x_addr_d     = x_addr_q;
    x_data_d     = x_data_q;
    core_start_d = 1'b0;
    m_valid_d    = m_valid_q;
    m_digit_d    = m_digit_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_LOAD: begin
        if (hs) begin
          // Every accepted pixel is written, including the one that
          // reveals a framing error.
          x_we_d   = 1'b1;
          x_addr_d = cnt_q;
          x_data_d = sat8(s_data);
          if (at_last_pix) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = S_START;
            end else begin
              err_long_d = 1'b1;
              state_d    = S_FLUSH;
            end
          end else if (s_last) begin
            cnt_d       = '0;
            err_short_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      S_FLUSH: begin
        // Drain the rest of an over-long frame without touching the buffer.
        if (hs && s_last) begin
          state_d = S_LOAD;
        end
      end

      S_START: begin
        // Entered on the edge that registers the final write, so the start
        // pulse lands in the cycle right after that write.
        core_start_d = 1'b1;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (core_done) begin
          m_digit_d = core_digit;
          m_valid_d = 1'b1;
          state_d   = S_RESULT;
        end
      end

      S_RESULT: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_LOAD;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // s_ready is registered from the next state so that it stays low while
  // reset is held and rises on the first edge after release.
  always_comb begin
    s_ready_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      s_ready_q    <= 1'b0;
      x_we_q       <= 1'b0;
      x_addr_q     <= '0;
      x_data_q     <= '0;
      core_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_digit_q    <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= s_ready_d;
      x_we_q       <= x_we_d;
      x_addr_q     <= x_addr_d;
      x_data_q     <= x_data_d;
      core_start_q <= core_start_d;
      m_valid_q    <= m_valid_d;
      m_digit_q    <= m_digit_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign x_we       = x_we_q;
  assign x_addr     = x_addr_q;
  assign x_data     = x_data_q;
  assign core_start = core_start_q;
  assign m_valid    = m_valid_q;
  assign m_digit    = m_digit_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != S_LOAD);

endmodule

// File: tb/tb_image_loader.sv
// -----------------------------------------------------------------------------
// tb_image_loader
//
// Randomised bench for image_loader with IN_DIM=4. The stimulus side computes,
// per frame, what the loader must produce (buffer writes, error pulses, core
// starts, result digits) and queues it; a negedge monitor pops and compares
// whenever the DUT presents a write, a start pulse or a result handshake.
// -----------------------------------------------------------------------------
module tb_image_loader;

  localparam int N  = 4;
  localparam int ZP = 128;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'd0;
  logic          s_last = 1'b0;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [7:0]    x_data;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = 4'd0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [3:0]    m_digit;
  logic          busy;
  logic          err_short;
  logic          err_long;
  logic [15:0]   frame_cnt;

  image_loader #(.IN_DIM(N), .ZERO_POINT(ZP)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .x_we       (x_we),
    .x_addr     (x_addr),
    .x_data     (x_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_digit    (m_digit),
    .busy       (busy),
    .err_short  (err_short),
    .err_long   (err_long),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_res[$];
  int  pix_q[$];

  int checks = 0;
  int errors = 0;
  int short_cnt = 0, long_cnt = 0, start_cnt = 0;
  int exp_short = 0, exp_long = 0, exp_start = 0, exp_frames = 0;
  int last_hs_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion: unsigned pixel minus zero point, clamped to int8.
  function automatic int sat_ref(input int p);
    int d;
    d = p - ZP;
    if (d > 127) return 127;
    if (d < -128) return -128;
    return d;
  endfunction

  // ---------------------------------------------------------------- monitor
  wr_t mon_w;
  always @(negedge clk) begin
    if (!rst) begin
      if (x_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, none expected", x_addr, $signed(x_data));
        end else begin
          mon_w = exp_wr.pop_front();
          chk("x_addr", int'(x_addr), mon_w.addr);
          chk("x_data", int'($signed(x_data)), mon_w.data);
          $display("write addr=%0d data=%0d", x_addr, $signed(x_data));
        end
      end
      if (err_short) short_cnt++;
      if (err_long) long_cnt++;
      if (core_start) begin
        start_cnt++;
        chk("start_latency", cyc, last_hs_cyc + 1);
        $display("core_start at cycle %0d", cyc);
      end
      if (m_valid && m_ready) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: digit %0d, none expected", m_digit);
        end else begin
          chk("m_digit", int'(m_digit), exp_res.pop_front());
          $display("result digit=%0d", m_digit);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends pix_q as one packet with s_last on its final pixel, after queuing
  // the frame-level expectations.
  task automatic send_frame(input bit gaps);
    int  len, nwr, t;
    bit  rdy, done;
    wr_t w;
    len = pix_q.size();
    nwr = (len < N) ? len : N;
    for (int i = 0; i < nwr; i++) begin
      w.addr = i;
      w.data = sat_ref(pix_q[i]);
      exp_wr.push_back(w);
    end
    if (len < N) exp_short++;
    else if (len > N) exp_long++;
    else exp_start++;
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        s_valid = 1'b0;
        idle($urandom_range(3, 1));
      end
      s_valid = 1'b1;
      s_data  = 8'(pix_q[i]);
      s_last  = (i == len - 1);
      t = 0;
      done = 1'b0;
      while (!done) begin
        rdy = s_ready;
        @(posedge clk);
        #1;
        if (rdy) done = 1'b1;
        else begin
          t++;
          if (t > 50) begin
            checks++;
            errors++;
            $display("FAIL pixel_accept_timeout: s_ready stayed %0d, required 1", s_ready);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
          end
        end
      end
      if (i == len - 1) last_hs_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Waits for the core start, answers with a digit after a delay, and holds
  // m_ready low for 'hold' cycles before accepting the result.
  task automatic run_inference(input int digit, input int delay, input int hold);
    int t;
    t = 0;
    while (start_cnt < exp_start && t < 20) begin
      idle(1);
      t++;
    end
    chk("core_start_count", start_cnt, exp_start);
    chk("busy_wait", int'(busy), 1);
    idle(delay);
    if (hold == 0) m_ready = 1'b1;
    core_done  = 1'b1;
    core_digit = 4'(digit);
    exp_res.push_back(digit);
    idle(1);
    core_done  = 1'b0;
    core_digit = 4'($urandom);
    chk("m_valid_latency", int'(m_valid), 1);
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      chk("s_ready_hold", int'(s_ready), 0);
      chk("m_valid_hold", int'(m_valid), 1);
      chk("m_digit_hold", int'(m_digit), digit);
      idle(1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    exp_frames++;
    chk("m_valid_fall", int'(m_valid), 0);
    chk("frame_cnt", int'(frame_cnt), exp_frames);
    chk("s_ready_after_result", int'(s_ready), 1);
    chk("busy_after_result", int'(busy), 0);
  endtask

  task automatic check_counts();
    chk("err_short_count", short_cnt, exp_short);
    chk("err_long_count", long_cnt, exp_long);
    chk("core_start_count", start_cnt, exp_start);
    chk("writes_pending", exp_wr.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_x_we"}, int'(x_we), 0);
    chk({tag, "_x_addr"}, int'(x_addr), 0);
    chk({tag, "_x_data"}, int'(x_data), 0);
    chk({tag, "_core_start"}, int'(core_start), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_digit"}, int'(m_digit), 0);
    chk({tag, "_err_short"}, int'(err_short), 0);
    chk({tag, "_err_long"}, int'(err_long), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic random_frame(input int len);
    pix_q.delete();
    for (int i = 0; i < len; i++) pix_q.push_back(int'($urandom_range(255, 0)));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int len;
    rst = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    chk("s_ready_before_first_edge", int'(s_ready), 0);
    idle(1);
    chk("s_ready_after_reset", int'(s_ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    // Full frame with fixed pixels, digit 7 five cycles after start.
    $display("scenario full frame");
    pix_q = '{0, 128, 255, 200};
    send_frame(1'b0);
    run_inference(7, 5, 0);
    check_counts();

    // Short frame: s_last on the 2nd pixel.
    $display("scenario short frame");
    pix_q = '{10, 20};
    send_frame(1'b0);
    idle(2);
    check_counts();
    chk("busy_after_short", int'(busy), 0);
    random_frame(N);
    send_frame(1'b0);
    run_inference(2, 1, 0);
    check_counts();

    // Long frame: 6 pixels, s_last on the 6th.
    $display("scenario long frame");
    random_frame(6);
    send_frame(1'b0);
    idle(2);
    check_counts();
    chk("s_ready_after_flush", int'(s_ready), 1);

    // Backpressure: gappy input, result held for 10 cycles.
    $display("scenario backpressure");
    random_frame(N);
    send_frame(1'b1);
    run_inference(int'($urandom_range(15, 0)), 2, 10);
    random_frame(N);
    send_frame(1'b0);
    run_inference(5, 0, 0);
    check_counts();

    // Stray done while loading.
    $display("scenario stray done");
    core_done  = 1'b1;
    core_digit = 4'd3;
    idle(1);
    core_done = 1'b0;
    chk("stray_m_valid", int'(m_valid), 0);
    chk("stray_busy", int'(busy), 0);
    idle(3);
    chk("stray_m_valid_later", int'(m_valid), 0);

    // Randomised frames.
    $display("scenario random");
    for (int f = 0; f < 25; f++) begin
      len = ($urandom_range(1, 0) == 1) ? N : int'($urandom_range(7, 1));
      if ($urandom_range(3, 0) == 0) begin
        core_done = 1'b1;
        idle(1);
        core_done = 1'b0;
        chk("rand_stray_m_valid", int'(m_valid), 0);
      end
      random_frame(len);
      send_frame(1'($urandom));
      if (len == N) run_inference(int'($urandom_range(15, 0)), int'($urandom_range(6, 0)),
                                  int'($urandom_range(3, 0)));
      else idle(2);
      check_counts();
    end

    // Reset while waiting on the core.
    $display("scenario reset in wait");
    random_frame(N);
    send_frame(1'b0);
    idle(3);
    chk("start_before_reset", start_cnt, exp_start);
    chk("busy_before_reset", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_frames = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    core_done  = 1'b1;
    core_digit = 4'd9;
    idle(1);
    core_done = 1'b0;
    chk("late_done_m_valid", int'(m_valid), 0);
    chk("late_done_busy", int'(busy), 0);
    random_frame(N);
    send_frame(1'b0);
    run_inference(4, 2, 0);
    check_counts();
    chk("results_pending", exp_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
